// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable pattern, overlap mode
// and a saturating match counter.
module seq_detect_param #(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(4'b1101),
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             i,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             ovl,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] pat
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;

  logic             acc;
  logic             match;
  logic [PAT_W-1:0] hist_sh;
  logic [FW-1:0]    fill_inc;

  always_comb begin
    acc      = en & ~load;
    hist_sh  = {hist_q[PAT_W-2:0], i};
    fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    match    = acc && (fill_inc == FULL)
               && (hist_sh == pat_q);

    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    y_d    = match;
    cnt_d  = cnt_q;

    if (load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (acc) begin
      hist_d = hist_sh;
      // non-overlap mode restarts the fill so no bit is reused
      fill_d = (match && !ovl) ? '0 : fill_inc;
    end

    if (clr_cnt)
      cnt_d = '0;
    else if (match && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PAT_INIT;
      cnt_q  <= '0;
      y_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
    end
  end

  assign y         = y_q;
  assign match_cnt = cnt_q;
  assign pat       = pat_q;

endmodule
